// File: rtl/pmp_check_arb.sv
// rtl/pmp_check_arb.sv - two-requester arbiter in front of a shared combinational PMP checker
module pmp_check_arb #(
  parameter int PLEN  = 33,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       io_prv,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [PLEN:0]    if_addr,
  input  logic             if_flush,
  input  logic             ls_valid,
  output logic             ls_ready,
  input  logic [PLEN:0]    ls_addr,
  input  logic [1:0]       ls_size,
  input  logic             ls_r,
  input  logic             ls_w,
  output logic             if_rsp_valid,
  output logic             if_rsp_exc,
  output logic             ls_rsp_valid,
  output logic             ls_rsp_exc,
  output logic             chk_req,
  output logic [PLEN:0]    chk_addr,
  output logic [1:0]       chk_size,
  output logic             chk_r,
  output logic             chk_w,
  output logic             chk_x,
  output logic [1:0]       chk_prv,
  input  logic             chk_exception,
  output logic [CNT_W-1:0] deny_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    RESP  = 2'b10
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t        state;
  logic          rr;
  logic          owner_q;
  logic          exc_q;
  logic          flush_q;
  logic [PLEN:0] addr_q;
  logic [1:0]    size_q;
  logic [1:0]    prv_q;
  logic          r_q;
  logic          w_q;
  logic          x_q;
  logic          if_flush_hit;
  logic          deliver_exc;

  // Grant only in IDLE; a sole requester wins, a contended grant follows rr.
  always_comb begin
    if_ready = 1'b0;
    ls_ready = 1'b0;
    if ((state == IDLE) && !reset) begin
      if_ready = if_valid & (!ls_valid | (rr == OWN_IF));
      ls_ready = ls_valid & (!if_valid | (rr == OWN_LS));
    end
  end

  // A flush seen in CHECK (remembered in flush_q) or in RESP kills the fetch response.
  assign if_flush_hit = (owner_q == OWN_IF) & (flush_q | if_flush);

  assign if_rsp_valid = (state == RESP) & (owner_q == OWN_IF) & !if_flush_hit;
  assign ls_rsp_valid = (state == RESP) & (owner_q == OWN_LS);
  assign if_rsp_exc   = if_rsp_valid & exc_q;
  assign ls_rsp_exc   = ls_rsp_valid & exc_q;
  assign deliver_exc  = (if_rsp_valid | ls_rsp_valid) & exc_q;

  // Checker drive comes straight from the latched request so it holds between checks.
  assign chk_req  = (state == CHECK);
  assign chk_addr = addr_q;
  assign chk_size = size_q;
  assign chk_r    = r_q;
  assign chk_w    = w_q;
  assign chk_x    = x_q;
  assign chk_prv  = prv_q;

  // Control FSM: IDLE -> CHECK -> RESP -> IDLE, with round-robin and verdict capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rr      <= OWN_IF;
      owner_q <= OWN_IF;
      exc_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_ready) begin
            state   <= CHECK;
            owner_q <= OWN_IF;
            rr      <= OWN_LS;
            flush_q <= 1'b0;
          end else if (ls_ready) begin
            state   <= CHECK;
            owner_q <= OWN_LS;
            rr      <= OWN_IF;
            flush_q <= 1'b0;
          end
        end
        CHECK: begin
          exc_q   <= chk_exception;
          flush_q <= (owner_q == OWN_IF) & if_flush;
          state   <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request latch: fields are captured at the handshake so later input changes are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      size_q <= 2'b00;
      prv_q  <= 2'b00;
      r_q    <= 1'b0;
      w_q    <= 1'b0;
      x_q    <= 1'b0;
    end else if (if_ready) begin
      addr_q <= if_addr;
      size_q <= 2'b10;
      prv_q  <= io_prv;
      r_q    <= 1'b0;
      w_q    <= 1'b0;
      x_q    <= 1'b1;
    end else if (ls_ready) begin
      addr_q <= ls_addr;
      size_q <= ls_size;
      prv_q  <= io_prv;
      r_q    <= ls_r;
      w_q    <= ls_w;
      x_q    <= 1'b0;
    end
  end

  // Denied-access counter: counts delivered faulting responses, sticks at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      deny_cnt <= '0;
    end else if (deliver_exc && (deny_cnt != CNT_MAX)) begin
      deny_cnt <= deny_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pmp_check_arb.sv
// tb/tb_pmp_check_arb.sv - self-checking bench for pmp_check_arb
module tb_pmp_check_arb;
  localparam int PLEN = 33;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset;
  logic [1:0]      io_prv;
  logic            if_valid, ls_valid, if_flush;
  logic [PLEN:0]   if_addr, ls_addr;
  logic [1:0]      ls_size;
  logic            ls_r, ls_w, chk_exception;

  logic            if_ready, ls_ready;
  logic            if_rsp_valid, if_rsp_exc, ls_rsp_valid, ls_rsp_exc;
  logic            chk_req, chk_r, chk_w, chk_x;
  logic [PLEN:0]   chk_addr;
  logic [1:0]      chk_size, chk_prv;
  logic [15:0]     deny_cnt;

  logic            d2_if_ready, d2_ls_ready;
  logic            d2_if_rsp_valid, d2_if_rsp_exc, d2_ls_rsp_valid, d2_ls_rsp_exc;
  logic            d2_chk_req, d2_chk_r, d2_chk_w, d2_chk_x;
  logic [PLEN:0]   d2_chk_addr;
  logic [1:0]      d2_chk_size, d2_chk_prv;
  logic [1:0]      d2_deny_cnt;

  pmp_check_arb #(.PLEN(PLEN), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .io_prv(io_prv),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr), .if_flush(if_flush),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_r(ls_r), .ls_w(ls_w),
    .if_rsp_valid(if_rsp_valid), .if_rsp_exc(if_rsp_exc),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_exc(ls_rsp_exc),
    .chk_req(chk_req), .chk_addr(chk_addr), .chk_size(chk_size), .chk_r(chk_r),
    .chk_w(chk_w), .chk_x(chk_x), .chk_prv(chk_prv), .chk_exception(chk_exception),
    .deny_cnt(deny_cnt)
  );

  pmp_check_arb #(.PLEN(PLEN), .CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .io_prv(io_prv),
    .if_valid(if_valid), .if_ready(d2_if_ready), .if_addr(if_addr), .if_flush(if_flush),
    .ls_valid(ls_valid), .ls_ready(d2_ls_ready), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_r(ls_r), .ls_w(ls_w),
    .if_rsp_valid(d2_if_rsp_valid), .if_rsp_exc(d2_if_rsp_exc),
    .ls_rsp_valid(d2_ls_rsp_valid), .ls_rsp_exc(d2_ls_rsp_exc),
    .chk_req(d2_chk_req), .chk_addr(d2_chk_addr), .chk_size(d2_chk_size), .chk_r(d2_chk_r),
    .chk_w(d2_chk_w), .chk_x(d2_chk_x), .chk_prv(d2_chk_prv), .chk_exception(chk_exception),
    .deny_cnt(d2_deny_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; ls_valid = 1'b0; if_flush = 1'b0; chk_exception = 1'b0;
    if_addr = '0; ls_addr = '0; ls_size = 2'b00; ls_r = 1'b0; ls_w = 1'b0; io_prv = 2'b00;
  endtask

  task automatic do_reset(input bit check_state);
    reset = 1'b1;
    idle_inputs();
    if_valid = 1'b1;
    ls_valid = 1'b1;
    smp();
    nxt();
    smp();
    if (check_state) begin
      check("rst_if_ready", if_ready, 0);
      check("rst_ls_ready", ls_ready, 0);
      check("rst_chk_req", chk_req, 0);
      check("rst_if_rsp_valid", if_rsp_valid, 0);
      check("rst_ls_rsp_valid", ls_rsp_valid, 0);
      check("rst_deny_cnt", deny_cnt, 0);
      check("rst_chk_addr", chk_addr, 0);
      check("rst_chk_prv", chk_prv, 0);
    end
    nxt();
    reset = 1'b0;
    idle_inputs();
  endtask

  typedef struct packed {
    logic ifv, lsv, exc;
    logic e_ifr, e_lsr, e_chk, e_ifrsp, e_lsrsp;
    logic e_exc;
  } vec_t;

  vec_t vt [10];

  // reference model state for the random phase
  int          cyc, free_at, t_start;
  logic        rr_m;
  logic        t_owner, t_r, t_w, t_x, t_exc, t_fl;
  logic [PLEN:0] t_addr;
  logic [1:0]  t_size, t_prv;
  int          cnt1, cnt2;
  logic        ifp, lsp;
  logic [63:0] r64;
  bit          idle_m, in_chk, in_rsp, e_ifr, e_lsr, e_ifrsp, e_lsrsp;
  int          exp2 [5];

  initial begin
    reset = 1'b1;
    idle_inputs();
    nxt();

    // reset state, then contention alternation and sole-requester grant
    do_reset(1'b1);
    vt[0] = {3'b110, 5'b10000, 1'b0};
    vt[1] = {3'b111, 5'b00100, 1'b0};
    vt[2] = {3'b110, 5'b00010, 1'b1};
    vt[3] = {3'b110, 5'b01000, 1'b0};
    vt[4] = {3'b110, 5'b00100, 1'b0};
    vt[5] = {3'b110, 5'b00001, 1'b0};
    vt[6] = {3'b110, 5'b10000, 1'b0};
    vt[7] = {3'b110, 5'b00100, 1'b0};
    vt[8] = {3'b110, 5'b00010, 1'b0};
    vt[9] = {3'b100, 5'b10000, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if_valid = vt[i].ifv;
      ls_valid = vt[i].lsv;
      chk_exception = vt[i].exc;
      smp();
      check($sformatf("vec%0d_if_ready", i), if_ready, vt[i].e_ifr);
      check($sformatf("vec%0d_ls_ready", i), ls_ready, vt[i].e_lsr);
      check($sformatf("vec%0d_chk_req", i), chk_req, vt[i].e_chk);
      check($sformatf("vec%0d_if_rsp_valid", i), if_rsp_valid, vt[i].e_ifrsp);
      check($sformatf("vec%0d_ls_rsp_valid", i), ls_rsp_valid, vt[i].e_lsrsp);
      check($sformatf("vec%0d_rsp_exc", i), if_rsp_exc | ls_rsp_exc, vt[i].e_exc);
      nxt();
    end

    // denied store
    do_reset(1'b0);
    ls_valid = 1'b1; ls_addr = 34'h100; ls_w = 1'b1; ls_r = 1'b0; ls_size = 2'b10; io_prv = 2'b01;
    smp();
    check("st_ls_ready", ls_ready, 1);
    check("st_if_ready", if_ready, 0);
    nxt();
    ls_valid = 1'b0; chk_exception = 1'b1;
    smp();
    check("st_chk_req", chk_req, 1);
    check("st_chk_addr", chk_addr, 34'h100);
    check("st_chk_w", chk_w, 1);
    check("st_chk_r", chk_r, 0);
    check("st_chk_x", chk_x, 0);
    check("st_chk_prv", chk_prv, 2'b01);
    nxt();
    chk_exception = 1'b0;
    smp();
    check("st_ls_rsp_valid", ls_rsp_valid, 1);
    check("st_ls_rsp_exc", ls_rsp_exc, 1);
    check("st_if_rsp_valid", if_rsp_valid, 0);
    check("st_deny_before", deny_cnt, 0);
    nxt();
    smp();
    check("st_deny_after", deny_cnt, 1);
    check("st_rsp_gone", ls_rsp_valid, 0);
    nxt();

    // fetch flushed during CHECK
    do_reset(1'b0);
    if_valid = 1'b1; if_addr = 34'h2000;
    smp();
    check("fl_if_ready", if_ready, 1);
    nxt();
    if_valid = 1'b0; if_flush = 1'b1; chk_exception = 1'b1;
    smp();
    check("fl_chk_req", chk_req, 1);
    check("fl_chk_x", chk_x, 1);
    check("fl_chk_size", chk_size, 2'b10);
    nxt();
    if_flush = 1'b0; chk_exception = 1'b0;
    smp();
    check("fl_if_rsp_valid", if_rsp_valid, 0);
    check("fl_ls_rsp_valid", ls_rsp_valid, 0);
    nxt();
    if_valid = 1'b1;
    smp();
    check("fl_idle_ready", if_ready, 1);
    check("fl_deny_cnt", deny_cnt, 0);
    nxt();

    // reset pulsed during CHECK
    do_reset(1'b0);
    if_valid = 1'b1; ls_valid = 1'b1;
    smp();
    check("rc_if_ready", if_ready, 1);
    nxt();
    reset = 1'b1;
    smp();
    check("rc_chk_req", chk_req, 1);
    check("rc_ready_in_rst", if_ready | ls_ready, 0);
    nxt();
    reset = 1'b0;
    smp();
    check("rc_if_rsp", if_rsp_valid, 0);
    check("rc_ls_rsp", ls_rsp_valid, 0);
    check("rc_ready_after", if_ready, 1);
    nxt();
    if_valid = 1'b0; ls_valid = 1'b0;
    smp();
    check("rc_if_rsp2", if_rsp_valid, 0);
    check("rc_ls_rsp2", ls_rsp_valid, 0);
    nxt();

    // saturation of a 2-bit counter over five denied responses
    do_reset(1'b0);
    exp2 = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      ls_valid = 1'b1; ls_r = 1'b1; ls_w = 1'b0;
      smp(); nxt();
      ls_valid = 1'b0; chk_exception = 1'b1;
      smp(); nxt();
      chk_exception = 1'b0;
      smp(); nxt();
      check($sformatf("sat%0d_cnt2", i), d2_deny_cnt, exp2[i]);
      check($sformatf("sat%0d_cnt16", i), deny_cnt, i + 1);
    end

    // privilege captured at handshake
    do_reset(1'b0);
    if_valid = 1'b1; io_prv = 2'b11;
    smp(); nxt();
    if_valid = 1'b0; io_prv = 2'b00;
    smp();
    check("prv_chk_req", chk_req, 1);
    check("prv_chk_prv", chk_prv, 2'b11);
    nxt();

    // randomized traffic against a transaction-level model
    do_reset(1'b0);
    free_at = 0; t_start = -100; rr_m = 1'b0;
    t_owner = 1'b0; t_addr = '0; t_size = 2'b00; t_prv = 2'b00;
    t_r = 1'b0; t_w = 1'b0; t_x = 1'b0; t_exc = 1'b0; t_fl = 1'b0;
    cnt1 = 0; cnt2 = 0; ifp = 1'b0; lsp = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (!ifp && ($urandom_range(1, 0) == 1)) begin
        ifp = 1'b1;
        r64 = {$urandom(), $urandom()};
        if_addr = r64[PLEN:0];
      end
      if (!lsp && ($urandom_range(1, 0) == 1)) begin
        lsp = 1'b1;
        r64 = {$urandom(), $urandom()};
        ls_addr = r64[PLEN:0];
        ls_size = 2'($urandom_range(3, 0));
        ls_r = 1'($urandom_range(1, 0));
        ls_w = 1'($urandom_range(1, 0));
      end
      if_valid = ifp;
      ls_valid = lsp;
      io_prv = 2'($urandom_range(3, 0));
      chk_exception = 1'($urandom_range(1, 0));
      if_flush = ($urandom_range(7, 0) == 0);
      smp();

      idle_m = (cyc >= free_at);
      e_ifr = idle_m && if_valid && (!ls_valid || !rr_m);
      e_lsr = idle_m && ls_valid && (!if_valid || rr_m);
      in_chk = (cyc == t_start + 1);
      in_rsp = (cyc == t_start + 2);
      if (in_chk) t_exc = chk_exception;
      if ((in_chk || in_rsp) && !t_owner && if_flush) t_fl = 1'b1;
      e_ifrsp = in_rsp && !t_owner && !t_fl;
      e_lsrsp = in_rsp && t_owner;

      check("rnd_if_ready", if_ready, e_ifr);
      check("rnd_ls_ready", ls_ready, e_lsr);
      check("rnd_chk_req", chk_req, in_chk);
      check("rnd_chk_addr", chk_addr, t_addr);
      check("rnd_chk_size", chk_size, t_size);
      check("rnd_chk_rwx", {chk_r, chk_w, chk_x}, {t_r, t_w, t_x});
      check("rnd_chk_prv", chk_prv, t_prv);
      check("rnd_if_rsp_valid", if_rsp_valid, e_ifrsp);
      check("rnd_ls_rsp_valid", ls_rsp_valid, e_lsrsp);
      check("rnd_if_rsp_exc", if_rsp_exc, e_ifrsp && t_exc);
      check("rnd_ls_rsp_exc", ls_rsp_exc, e_lsrsp && t_exc);
      check("rnd_deny_cnt", deny_cnt, cnt1);
      check("rnd_deny_cnt2", d2_deny_cnt, cnt2);

      if ((e_ifrsp || e_lsrsp) && t_exc) begin
        cnt1 = (cnt1 < 65535) ? cnt1 + 1 : 65535;
        cnt2 = (cnt2 < 3) ? cnt2 + 1 : 3;
      end
      if (e_ifr || e_lsr) begin
        t_owner = e_lsr;
        t_addr  = e_ifr ? if_addr : ls_addr;
        t_size  = e_ifr ? 2'b10 : ls_size;
        t_r     = e_ifr ? 1'b0 : ls_r;
        t_w     = e_ifr ? 1'b0 : ls_w;
        t_x     = e_ifr;
        t_prv   = io_prv;
        t_exc   = 1'b0;
        t_fl    = 1'b0;
        t_start = cyc;
        free_at = cyc + 3;
        rr_m    = e_ifr;
        if (e_ifr) ifp = 1'b0;
        else lsp = 1'b0;
      end
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
